video_scandoubler: RTL and testbench
====================================

// Module: video_scandoubler
// PURPOSE
//  Line-doubling stage downstream of the CRAM/palette output stage: takes 8:8:8 RGB + DAC-mode
//  at TV pixel rate, stores each line in a ping-pong line buffer, and replays the previous line
//  twice at double pixel rate. Output goes to the VGA DAC; also regenerates line-aligned syncs.
// PARAMETERS
//  ADDR_W     10   line buffer address width; MAX_PIX = 2**ADDR_W pixels per line
//  HS_LEN     32   output hsync width, in output pixel strobes
// PORTS
//  clk          in   1   system video clock
//  rst_n        in   1   asynchronous reset, active low
//  pix_ce_in    in   1   input pixel strobe, 1-clk pulse (c3 phase)
//  pix_ce_out   in   1   output pixel strobe, 1-clk pulse, exactly 2x pix_ce_in rate
//  hsync_in     in   1   TV-rate hsync, active high
//  vsync_in     in   1   TV-rate vsync, active high
//  red_in/grn_in/blu_in  in  8 each  pixel colour from palette stage
//  mode_in      in   1   vdac_mode of that pixel
//  scanlines    in   1   dim second pass (used only with VIDEO_SCANLINES_EN)
//  red_out/grn_out/blu_out out 8 each  doubled-rate colour
//  mode_out     out  1   doubled-rate vdac_mode
//  hsync_out    out  1   VGA hsync, active high
//  vsync_out    out  1   VGA vsync, active high, line aligned
// BEHAVIOUR
//  - Reset: all outputs 0; wr_addr=rd_addr=0; bank=0; line_len=0; pass=0.
//  - Buffer: 2 banks x MAX_PIX x 25 bits {mode,r,g,b}; input writes bank `bank`, output reads `~bank`.
//  - Line start = rising edge of hsync_in (previous-cycle register compare, sampled every clk).
//    At line start: line_len <= wr_addr (saturated), bank toggles, wr_addr <= 0, rd_addr <= 0,
//    pass <= 0, vsync_out <= vsync_in, hsync counter restarts.
//  - Write: on pix_ce_in, if wr_addr < MAX_PIX write pixel at wr_addr, wr_addr++ saturating at
//    MAX_PIX (excess pixels dropped). Line start and pix_ce_in same cycle: edge wins; that pixel
//    is written at address 0 of the new bank and wr_addr becomes 1.
//  - Read: on pix_ce_out, RAM read at rd_addr; rd_addr++. When rd_addr+1 == line_len and pass==0:
//    rd_addr <= 0, pass <= 1, hsync counter restarts. After pass 1 completes, rd_addr holds at
//    line_len and output is black until next line start.
//  - Latency: pixel read on strobe n appears on outputs at strobe n+1 (one output pixel).
//  - Pixels beyond line_len, and any line with line_len==0 (incl. first line after reset): RGB and
//    mode_out = 0.
//  - hsync_out = 1 for the first HS_LEN output strobes of each pass, aligned with output pixel 0.
//  - Reset mid-line: all state cleared immediately; output black until 2nd input line start.
// CONFIGURATION
//  VIDEO_SCANLINES_EN defined: when scanlines=1, pass-1 RGB are each shifted right by 1 (50%),
//   mode_out unaffected; scanlines sampled at line start only.
//  Not defined: scanlines ignored, both passes identical; no dimming logic synthesised.
// TESTING
//  - Reset release, 2 lines of 448 px ramp (r=addr[7:0]) -> line 1 black; line 2 shows ramp twice,
//    each pass 448 px, hsync_out high 32 strobes at each pass start.
//  - Line of 1100 px, ADDR_W=10 -> line_len=1024, px 1024..1099 dropped, replay 1024 px x2.
//  - hsync_in edge coincident with pix_ce_in carrying 0xABCDEF -> it appears as pixel 0 next line.
//  - vsync_in rises mid-line -> vsync_out changes only at next hsync_in rising edge.
//  - VIDEO_SCANLINES_EN, scanlines=1, pixel 0xFF8040 -> pass 0 FF8040, pass 1 7F4020; undefined:
//    both FF8040.
//  - rst_n pulsed low mid-pass -> outputs 0 within same cycle (async), black until 2nd line start.

Source files
------------

// File: rtl/video_scandoubler.sv
// Line doubler: buffers each TV-rate line in a ping-pong RAM and replays it
// twice at 2x pixel rate with regenerated hsync and line-aligned vsync.
// Ports: clk, rst_n, pix_ce_in/out strobes, hsync_in, vsync_in,
//   red/grn/blu_in, mode_in, scanlines -> red/grn/blu_out, mode_out,
//   hsync_out, vsync_out. Option: VIDEO_SCANLINES_EN dims the second pass.
module video_scandoubler #(
  parameter int ADDR_W = 10,
  parameter int HS_LEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce_in,
  input  logic       pix_ce_out,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [7:0] red_in,
  input  logic [7:0] grn_in,
  input  logic [7:0] blu_in,
  input  logic       mode_in,
  input  logic       scanlines,
  output logic [7:0] red_out,
  output logic [7:0] grn_out,
  output logic [7:0] blu_out,
  output logic       mode_out,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam int MAXP = 2**ADDR_W;
  localparam int AW1  = ADDR_W + 1;
  localparam int HCW  = $clog2(HS_LEN + 1);
  localparam logic [ADDR_W:0] MAX_PIX = AW1'(MAXP);
  localparam logic [ADDR_W:0] ONE     = AW1'(1);
  localparam logic [HCW-1:0]  HS_END  = HCW'(HS_LEN);
  localparam logic [HCW-1:0]  HS_ONE  = HCW'(1);

  logic [24:0]     mem [2*MAXP];
  logic [24:0]     rd_data;
  logic [24:0]     px_nxt;
  logic [ADDR_W:0] wr_addr;
  logic [ADDR_W:0] rd_addr;
  logic [ADDR_W:0] line_len;
  logic [ADDR_W:0] waddr;
  logic [ADDR_W:0] raddr;
  logic [HCW-1:0]  hs_cnt;
  logic            hs_q;
  logic            bank;
  logic            pass;
  logic            armed;
  logic            line_start;
  logic            wr_en;
  logic            rd_en;
  logic            rd_vld;
  logic            rd_hs;
`ifdef VIDEO_SCANLINES_EN
  logic            sl_q;
  logic            rd_pass;
`else
  logic            unused_sl;
  assign unused_sl = scanlines;
`endif

  assign line_start = hsync_in & ~hs_q;
  assign wr_en = pix_ce_in & (line_start | (wr_addr < MAX_PIX));
  assign rd_en = pix_ce_out & ~line_start & (rd_addr < line_len);

  // a pixel coincident with the line start lands at 0 of the new bank
  assign waddr = line_start ? {~bank, {ADDR_W{1'b0}}}
                            : {bank, wr_addr[ADDR_W-1:0]};
  assign raddr = {~bank, rd_addr[ADDR_W-1:0]};

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[waddr] <= {mode_in, red_in, grn_in, blu_in};
  end

  always_ff @(posedge clk) begin
    if (rd_en)
      rd_data <= mem[raddr];
  end

  always_comb begin
    px_nxt = rd_vld ? rd_data : '0;
`ifdef VIDEO_SCANLINES_EN
    if (sl_q && rd_pass)
      px_nxt[23:0] = {1'b0, px_nxt[23:17],
                      1'b0, px_nxt[15:9],
                      1'b0, px_nxt[7:1]};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= 1'b0;
      bank      <= 1'b0;
      pass      <= 1'b0;
      armed     <= 1'b0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      line_len  <= '0;
      hs_cnt    <= '0;
      rd_vld    <= 1'b0;
      rd_hs     <= 1'b0;
      red_out   <= '0;
      grn_out   <= '0;
      blu_out   <= '0;
      mode_out  <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
`ifdef VIDEO_SCANLINES_EN
      sl_q      <= 1'b0;
      rd_pass   <= 1'b0;
`endif
    end else begin
      hs_q <= hsync_in;
      if (line_start) begin
        // the partial line seen right after reset is never replayed
        line_len  <= armed ? wr_addr : '0;
        armed     <= 1'b1;
        bank      <= ~bank;
        wr_addr   <= pix_ce_in ? ONE : '0;
        rd_addr   <= '0;
        pass      <= 1'b0;
        hs_cnt    <= '0;
        vsync_out <= vsync_in;
`ifdef VIDEO_SCANLINES_EN
        sl_q      <= scanlines;
`endif
      end else begin
        if (wr_en)
          wr_addr <= wr_addr + ONE;
        if (pix_ce_out && hs_cnt != HS_END)
          hs_cnt <= hs_cnt + HS_ONE;
        if (rd_en) begin
          if (rd_addr + ONE == line_len && !pass) begin
            rd_addr <= '0;
            pass    <= 1'b1;
            hs_cnt  <= '0;
          end else begin
            rd_addr <= rd_addr + ONE;
          end
        end
      end
      if (pix_ce_out && !line_start) begin
        rd_vld    <= rd_en;
        rd_hs     <= (hs_cnt != HS_END);
`ifdef VIDEO_SCANLINES_EN
        rd_pass   <= pass;
`endif
        mode_out  <= px_nxt[24];
        red_out   <= px_nxt[23:16];
        grn_out   <= px_nxt[15:8];
        blu_out   <= px_nxt[7:0];
        hsync_out <= rd_hs;
      end
    end
  end

endmodule

// File: tb/tb_video_scandoubler.sv
// Bench for video_scandoubler: directed lines, expected output pixels
// queued per (line, output strobe) and checked by a separate monitor.
module tb_video_scandoubler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_ce_in = 1'b0;
  logic       pix_ce_out = 1'b0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [7:0] red_in = '0;
  logic [7:0] grn_in = '0;
  logic [7:0] blu_in = '0;
  logic       mode_in = 1'b0;
  logic       scanlines = 1'b0;
  logic [7:0] red_out;
  logic [7:0] grn_out;
  logic [7:0] blu_out;
  logic       mode_out;
  logic       hsync_out;
  logic       vsync_out;

  video_scandoubler #(.ADDR_W(10), .HS_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_ce_in(pix_ce_in), .pix_ce_out(pix_ce_out),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .grn_in(grn_in), .blu_in(blu_in),
    .mode_in(mode_in), .scanlines(scanlines),
    .red_out(red_out), .grn_out(grn_out), .blu_out(blu_out),
    .mode_out(mode_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          line;
    int          k;
    logic [27:0] v;
  } item_t;

  item_t q[$];
  int    n_total = 0;
  int    n_pass = 0;
  int    mline = 0;
  int    kk = 0;
  logic  mon_hs_prev = 1'b0;
  int    lc = 0;

  function automatic logic [27:0] act();
    return {hsync_out, vsync_out, mode_out, red_out, grn_out, blu_out};
  endfunction

  // stimulus pixel pattern: r=a[7:0], g=a[9:8], b=a[10:3], mode=a[0]
  function automatic logic [24:0] pat(int kind, int a);
    logic [10:0] x;
    x = 11'(a);
    if (kind == 1 && a == 0) return 25'h1ABCDEF;
    if (kind == 2 && a == 0) return 25'h0FF8040;
    return {x[0], x[7:0], 6'b0, x[9:8], x[10:3]};
  endfunction

  task automatic chk(string name, logic [27:0] got, logic [27:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", name, got, exp);
    else
      n_pass++;
  endtask

  task automatic push(int line, int k, logic hs, logic vs, logic [24:0] px);
    item_t it;
    it.line = line;
    it.k = k;
    it.v = {hs, vs, px};
    q.push_back(it);
  endtask

  always @(posedge clk) begin
    if (hsync_in && !mon_hs_prev) begin
      mline++;
      kk = 0;
    end
    mon_hs_prev = hsync_in;
    if (pix_ce_out) begin
      kk++;
      #1;
      while (q.size() > 0 && (q[0].line < mline ||
             (q[0].line == mline && q[0].k < kk))) begin
        item_t m;
        m = q.pop_front();
        n_total++;
        $display("FAIL missed L%0d k%0d: got none expected %h",
                 m.line, m.k, m.v);
      end
      if (q.size() > 0 && q[0].line == mline && q[0].k == kk) begin
        item_t m;
        m = q.pop_front();
        chk($sformatf("L%0d k%0d", m.line, m.k), act(), m.v);
      end
    end
  end

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      for (int ph = 0; ph < 4; ph++) begin
        @(negedge clk);
        hsync_in   = 1'b0;
        pix_ce_in  = (ph == 0);
        pix_ce_out = (ph == 1 || ph == 3);
      end
    end
  endtask

  task automatic drive_line(int n, int kind, int vs_at, logic vs_val,
                            int sl_at, logic sl_val, int rst_at);
    logic rel;
    rel = 1'b0;
    lc++;
    for (int i = 0; i < n; i++) begin
      for (int ph = 0; ph < 4; ph++) begin
        @(negedge clk);
        pix_ce_in  = (ph == 0);
        pix_ce_out = (ph == 1 || ph == 3);
        if (rel) begin
          rst_n = 1'b1;
          rel = 1'b0;
        end
        if (ph == 0) begin
          hsync_in = (i < 2);
          {mode_in, red_in, grn_in, blu_in} = pat(kind, i);
          if (i == vs_at) vsync_in = vs_val;
          if (i == sl_at) scanlines = sl_val;
        end
        if (ph == 2 && i == rst_at) begin
          #2 rst_n = 1'b0;
          #1 chk("async reset", act(), 28'h0);
          rel = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle(4);
    chk("reset state", act(), 28'h0);
    rst_n = 1'b1;
    idle(4);

    // line 1: first line after reset, nothing to replay
    push(1, 100, 0, 0, 25'h0);
    drive_line(448, 0, -1, 0, -1, 0, -1);

    // line 2: ramp of line 1 twice, hsync 32 strobes per pass
    push(2, 2,   1, 0, pat(0, 0));
    push(2, 33,  1, 0, pat(0, 31));
    push(2, 34,  0, 0, pat(0, 32));
    push(2, 449, 0, 0, pat(0, 447));
    push(2, 450, 1, 0, pat(0, 0));
    push(2, 481, 1, 0, pat(0, 31));
    push(2, 482, 0, 0, pat(0, 32));
    push(2, 750, 0, 0, pat(0, 300));
    drive_line(448, 0, -1, 0, -1, 0, -1);

    // line 3: 1100 px written, vsync_in rises mid-line
    push(3, 2100, 0, 0, 25'h0);
    drive_line(1100, 0, 600, 1, -1, 0, -1);

    // line 4: replay saturated at 1024, vsync_out follows line start
    push(4, 2,    1, 1, pat(0, 0));
    push(4, 1025, 0, 1, pat(0, 1023));
    push(4, 1026, 1, 1, pat(0, 0));
    push(4, 2049, 0, 1, pat(0, 1023));
    push(4, 2050, 0, 1, 25'h0);
    drive_line(1100, 0, 500, 0, -1, 0, -1);

    // line 5: pixel 0 = ABCDEF arrives with the hsync edge
    push(5, 3, 1, 0, pat(0, 1));
    drive_line(448, 1, -1, 0, -1, 0, -1);

    // line 6: scanlines raised mid-line must not dim this replay
    push(6, 2,   1, 0, 25'h1ABCDEF);
    push(6, 3,   1, 0, pat(0, 1));
    push(6, 450, 1, 0, 25'h1ABCDEF);
    push(6, 451, 1, 0, pat(0, 1));
    drive_line(448, 2, -1, 0, 100, 1, -1);

    // line 7: second pass dimmed when the option is built in
    push(7, 2,   1, 0, 25'h0FF8040);
    push(7, 300, 0, 0, pat(0, 298));
`ifdef VIDEO_SCANLINES_EN
    push(7, 450, 1, 0, 25'h07F4020);
    push(7, 451, 1, 0, 25'h1000000);
`else
    push(7, 450, 1, 0, 25'h0FF8040);
    push(7, 451, 1, 0, 25'h1010000);
`endif
    drive_line(448, 0, -1, 0, 320, 0, 300);

    // line 8: first line start after mid-line reset stays black
    push(8, 100, 0, 0, 25'h0);
    push(8, 500, 0, 0, 25'h0);
    drive_line(448, 0, -1, 0, -1, 0, -1);

    // line 9: replay resumes
    push(9, 2,   1, 0, pat(0, 0));
    push(9, 200, 0, 0, pat(0, 198));
    drive_line(448, 0, -1, 0, -1, 0, -1);

    idle(8);
    while (q.size() > 0) begin
      item_t m;
      m = q.pop_front();
      n_total++;
      $display("FAIL leftover L%0d k%0d: got none expected %h",
               m.line, m.k, m.v);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
